// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage driving the IF/ID register over an imem req/ack handshake.
// Optional FETCH_PERF_EN adds fetch_count/stall_count performance counters.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_inst,
`ifdef FETCH_PERF_EN
  output logic        if_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`else
  output logic        if_valid
`endif
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, DROP} state_t;
  state_t      state;
  logic [31:0] pc, buf_inst, pc4n, tgt, new_inst;
  logic        deliver;
  assign pc4n = pc + 32'd4;
  assign tgt = {redirect_pc[31:2], 2'b00};
  assign new_inst = (state == HOLD) ? buf_inst : imem_rdata;
  // the buffered word keeps its PC in pc, which only advances on delivery
  assign deliver = !redirect && !stall &&
                   ((state == HOLD) || ((state == FETCH || state == WAIT) && imem_req && imem_ack));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      buf_inst <= NOP_INST;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      if_pc <= RESET_PC;
      if_pc4 <= RESET_PC + 32'd4;
      if_inst <= NOP_INST;
      if_valid <= 1'b0;
    end else if (redirect) begin
      pc <= tgt;
      if_valid <= 1'b0;
      if_inst <= NOP_INST;
      if (imem_req && !imem_ack) state <= DROP;
      else begin
        state <= FETCH;
        imem_req <= 1'b1;
        imem_addr <= tgt;
      end
    end else begin
      if (!stall) begin
        if_valid <= deliver;
        if_inst <= deliver ? new_inst : NOP_INST;
        if (deliver) begin
          if_pc <= pc;
          if_pc4 <= pc4n;
        end
      end
      case (state)
        FETCH, WAIT:
          if (!imem_req) begin
            imem_req <= 1'b1;
            imem_addr <= pc;
          end else if (imem_ack) begin
            if (stall) begin
              buf_inst <= imem_rdata;
              imem_req <= 1'b0;
              state <= HOLD;
            end else begin
              pc <= pc4n;
              imem_addr <= pc4n;
              state <= FETCH;
            end
          end else state <= WAIT;
        HOLD:
          if (!stall) begin
            pc <= pc4n;
            imem_req <= 1'b1;
            imem_addr <= pc4n;
            state <= FETCH;
          end
        DROP:
          if (imem_ack) begin
            imem_addr <= pc;
            state <= FETCH;
          end
        default: state <= FETCH;
      endcase
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      fetch_count <= fetch_count + {31'd0, deliver};
      stall_count <= stall_count + {31'd0, stall & if_valid};
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized fetch-stage bench with a program-order reference model and a latency-driven memory.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0, imem_ack = 1'b0, imem_req, if_valid;
  logic [31:0] redirect_pc = '0, imem_rdata = '0, imem_addr, if_pc, if_pc4, if_inst;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif
  int checks = 0, errors = 0, cnt = 0, lat_lo = 0, lat_hi = 0, delivered = 0;
  logic [31:0] exp_pc = '0;
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst),
`ifdef FETCH_PERF_EN
    .if_valid(if_valid), .fetch_count(fetch_count), .stall_count(stall_count)
`else
    .if_valid(if_valid)
`endif
  );
  always #5 clk = ~clk;
  // one cycle: drive inputs and the memory at negedge, then check the IF/ID register against program order
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    logic [31:0] p_pc, p_pc4, p_inst, p_addr;
    logic p_v, p_req;
    @(negedge clk);
    p_pc = if_pc; p_pc4 = if_pc4; p_inst = if_inst; p_v = if_valid; p_req = imem_req; p_addr = imem_addr;
    stall = s; redirect = r; redirect_pc = rp;
    imem_ack = 1'b0;
    if (imem_req) begin
      if (cnt == 0) begin
        imem_ack = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        cnt = $urandom_range(lat_hi, lat_lo);
      end else cnt--;
    end
    @(posedge clk); #1;
    if (p_req && !imem_ack) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
        errors++; $display("FAIL addr_stable: req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, p_addr);
      end
    end
    checks++;
    if (r) begin
      exp_pc = rp & 32'hFFFF_FFFC;
      if (if_valid !== 1'b0 || if_inst !== NOP) begin
        errors++; $display("FAIL redirect_bubble: valid=%b inst=%h, required 0/%h", if_valid, if_inst, NOP);
      end
    end else if (s) begin
      if ({if_valid, if_inst, if_pc, if_pc4} !== {p_v, p_inst, p_pc, p_pc4}) begin
        errors++; $display("FAIL stall_hold: %b %h %h %h, required %b %h %h %h", if_valid, if_inst, if_pc, if_pc4, p_v, p_inst, p_pc, p_pc4);
      end
    end else if (if_valid === 1'b1) begin
      if (if_pc !== exp_pc || if_inst !== (exp_pc ^ KEY) || if_pc4 !== exp_pc + 32'd4) begin
        errors++; $display("FAIL deliver: pc=%h inst=%h pc4=%h, required pc=%h inst=%h pc4=%h", if_pc, if_inst, if_pc4, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      delivered++;
    end else if (if_inst !== NOP || if_valid !== 1'b0) begin
      errors++; $display("FAIL bubble: valid=%b inst=%h, required 0/%h", if_valid, if_inst, NOP);
    end
  endtask
  task automatic do_reset(input int lo, input int hi);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lat_lo = lo; lat_hi = hi; cnt = $urandom_range(hi, lo); exp_pc = 32'h0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    @(negedge clk); #2;
    rst = 1'b1; #1;
    checks++;
    if ({imem_req, if_valid, if_inst, if_pc, if_pc4} !== {1'b0, 1'b0, NOP, 32'h0, 32'h4}) begin
      errors++; $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h pc4=%h", imem_req, if_valid, if_inst, if_pc, if_pc4);
    end
    @(negedge clk);
    rst = 1'b0; lat_lo = 0; lat_hi = 0; cnt = 0; exp_pc = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      errors++; $display("FAIL first_req: req=%b addr=%h valid=%b, required 1/0/0", imem_req, imem_addr, if_valid);
    end
  endtask
  task automatic test_stream();
    do_reset(0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'(4 * i)) begin
        errors++; $display("FAIL stream_%0d: valid=%b pc=%h, required 1/%h", i, if_valid, if_pc, 32'(4 * i));
      end
    end
  endtask
  task automatic test_latency();
    logic prev;
    int n;
    do_reset(3, 3);
    prev = 1'b0; n = delivered;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b0, 32'h0);
      checks++;
      if (prev && if_valid) begin
        errors++; $display("FAIL pulse: valid high two cycles in a row at cycle %0d", i);
      end
      prev = if_valid;
    end
    checks++;
    if (delivered - n != 10) begin
      errors++; $display("FAIL latency_count: delivered %0d, required 10", delivered - n);
    end
  endtask
  task automatic test_stall();
    do_reset(0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      checks++;
      if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'hC) begin
        errors++; $display("FAIL stall_frozen_%0d: req=%b valid=%b pc=%h, required 0/1/0000000c", i, imem_req, if_valid, if_pc);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h10 || imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      errors++; $display("FAIL stall_release: valid=%b pc=%h req=%b addr=%h, required 1/10/1/14", if_valid, if_pc, imem_req, imem_addr);
    end
  endtask
  task automatic test_redirect_drop();
    int k;
    do_reset(0, 0);
    k = 0;
    while (imem_addr !== 32'h20 && k < 20) begin step(1'b0, 1'b0, 32'h0); k++; end
    checks++;
    if (imem_addr !== 32'h20) begin
      errors++; $display("FAIL reach_20: addr=%h, required 00000020", imem_addr);
    end
    cnt = 3;
    step(1'b0, 1'b1, 32'h203);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL drop_hold: req=%b addr=%h, required 1/20", imem_req, imem_addr);
    end
    k = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h200) && k < 10) begin step(1'b0, 1'b0, 32'h0); k++; end
    checks++;
    if (imem_addr !== 32'h200) begin
      errors++; $display("FAIL drop_refetch: addr=%h, required 00000200", imem_addr);
    end
    k = 0;
    while (if_valid !== 1'b1 && k < 5) begin step(1'b0, 1'b0, 32'h0); k++; end
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      errors++; $display("FAIL drop_deliver: valid=%b pc=%h, required 1/200", if_valid, if_pc);
    end
  endtask
  task automatic test_wrap();
    do_reset(0, 0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL redirect_ack: valid=%b req=%b addr=%h, required 0/1/fffffffc", if_valid, imem_req, imem_addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap: pc=%h pc4=%h addr=%h, required fffffffc/0/0", if_pc, if_pc4, imem_addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL wrap_next: valid=%b pc=%h, required 1/0", if_valid, if_pc);
    end
  endtask
  task automatic test_rst_midflight();
    do_reset(0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
    @(negedge clk); #2;
    rst = 1'b1; imem_ack = 1'b0; #1;
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_inst !== NOP) begin
      errors++; $display("FAIL async_rst: req=%b valid=%b inst=%h, required 0/0/%h", imem_req, if_valid, if_inst, NOP);
    end
    @(negedge clk);
    rst = 1'b0; cnt = 0; exp_pc = 32'h0;
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_restart: req=%b addr=%h, required 1/0", imem_req, imem_addr);
    end
    step(1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++; $display("FAIL rst_deliver: valid=%b pc=%h, required 1/0", if_valid, if_pc);
    end
  endtask
  task automatic test_random();
    int n;
    do_reset(0, 3);
    n = delivered;
    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 3, $urandom_range(19, 0) == 0, $urandom);
    checks++;
    if (delivered - n < 40) begin
      errors++; $display("FAIL random_progress: delivered %0d, required at least 40", delivered - n);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect_drop();
    test_wrap();
    test_rst_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
